scalar_mult_sequencer: RTL and testbench
========================================

SCALAR_MULT_SEQUENCER -- requirements
Module: scalar_mult_sequencer

Interface
REQ-001 Parameter: KEY_W, default 256, scalar width in bits (power of two, 2..256).
REQ-002 Parameter: IDX_W, default 8, bit-index width = log2(KEY_W).
REQ-003 Port: clk  input  1  rising-edge clock; one clock; all state changes on posedge clk.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request to begin one scalar multiplication; sampled in IDLE only.
REQ-006 Port: abort  input  1  cancel the operation in progress.
REQ-007 Port: scalar  input  KEY_W  multiplier k; captured on accepted start.
REQ-008 Port: op_valid  output  1  operation request to the point-arithmetic unit.
REQ-009 Port: op_code  output  2  00 = point double, 01 = point add, 10/11 unused.
REQ-010 Port: op_ready  input  1  point unit accepts the request this cycle.
REQ-011 Port: op_done  input  1  point unit finished the accepted operation (one-cycle pulse).
REQ-012 Port: bit_index  output  IDX_W  index of the scalar bit being processed.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: done  output  1  one-cycle pulse on normal completion.
REQ-015 Port: aborted  output  1  one-cycle pulse when abort takes effect.

Function
REQ-016 Algorithm: left-to-right double-and-add, MSB (index KEY_W-1) down to bit 0; per bit one DOUBLE, then one ADD only when that scalar bit = 1.
REQ-017 States: IDLE, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, NEXT, FINISH.
REQ-018 IDLE: start=1 -> capture scalar, bit_index <= KEY_W-1, go to DBL_REQ next cycle; start=0 -> stay.
REQ-019 DBL_REQ: op_valid=1, op_code=00; op_ready=1 -> DBL_WAIT; else hold valid and code unchanged.
REQ-020 DBL_WAIT: op_valid=0; op_done=1 -> ADD_REQ if scalar[bit_index]=1, else NEXT.
REQ-021 ADD_REQ: op_valid=1, op_code=01; op_ready=1 -> ADD_WAIT; else hold.
REQ-022 ADD_WAIT: op_valid=0; op_done=1 -> NEXT.
REQ-023 NEXT (one cycle): bit_index=0 -> FINISH; else bit_index <= bit_index-1, go to DBL_REQ.
REQ-024 bit_index decrements only in NEXT; never wraps from 0 to KEY_W-1 inside one operation.
REQ-025 FINISH (one cycle): done=1, then IDLE; bit_index stays 0.
REQ-026 op_valid is never high for more than one outstanding op; no new request until the previous op_done.
REQ-027 op_done outside DBL_WAIT/ADD_WAIT is ignored; op_ready outside *_REQ states is ignored.
REQ-028 op_ready and op_done both high in a *_REQ state: only op_ready acts; op_done is ignored.
REQ-029 start while busy is ignored; the captured scalar does not change until the next accepted start.
REQ-030 abort in any non-IDLE state -> IDLE next cycle, aborted=1 for that one cycle, op_valid=0, done not pulsed; abort in IDLE has no effect.
REQ-031 abort and op_done in the same cycle: abort wins.
REQ-032 Total ops for scalar k: KEY_W doubles + popcount(k) adds.
REQ-033 Op sequence is fixed: a new op follows op_done by at least 1 cycle; each bit costs its ops plus 1 cycle in NEXT.

Reset
REQ-034 reset=1 at posedge: state IDLE, bit_index=0, captured scalar=0, op_valid=0, op_code=00, busy=0, done=0, aborted=0.
REQ-035 Reset overrides start and abort; reset mid-operation drops the operation with no done or aborted pulse.
REQ-036 Outputs are fully defined from the first clock edge after reset.

Verification
REQ-037 KEY_W=8, scalar=8'b1000_0001, op_ready=1, op_done 2 cycles after accept -> codes D,A,D,D,D,D,D,D,D,A (8 doubles, 2 adds), done pulses once, busy falls the next cycle.
REQ-038 scalar=0 -> 256 doubles, 0 adds, final bit_index=0, one done pulse.
REQ-039 op_ready held 0 for 5 cycles in DBL_REQ -> op_valid and op_code=00 stable all 5 cycles, exactly one DBL issued.
REQ-040 abort in ADD_WAIT at bit_index=0x80 -> aborted pulse, IDLE next cycle, no done; new start afterwards restarts at index 0xFF.
REQ-041 start pulsed mid-run with a different scalar -> op sequence unchanged from the first scalar; spurious op_done in NEXT produces no state change.
REQ-042 reset asserted during DBL_WAIT -> all REQ-034 values next cycle; no done or aborted pulse.

Source files
------------

// File: rtl/scalar_mult_sequencer.sv
// -----------------------------------------------------------------------------
// scalar_mult_sequencer
//
// Control sequencer for left-to-right double-and-add scalar multiplication.
// It walks the captured scalar from bit KEY_W-1 down to bit 0. For every bit
// it issues one point DOUBLE to the external point-arithmetic unit, then one
// point ADD when that scalar bit is 1. Only one operation is ever outstanding:
// a request is held until accepted (op_valid & op_ready), then the sequencer
// waits for the matching op_done pulse before doing anything else.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   begin one multiplication (honoured only while idle)
//   abort      in   cancel the operation in progress (ignored while idle)
//   scalar     in   KEY_W-bit multiplier, captured when start is accepted
//   op_valid   out  request to the point unit
//   op_code    out  2'b00 = point double, 2'b01 = point add
//   op_ready   in   point unit accepts the request in this cycle
//   op_done    in   one-cycle pulse: accepted operation has finished
//   bit_index  out  index of the scalar bit currently being processed
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse on normal completion
//   aborted    out  one-cycle pulse in the cycle after an abort took effect
// -----------------------------------------------------------------------------
module scalar_mult_sequencer #(
  parameter int KEY_W = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] scalar,
  output logic             op_valid,
  output logic [1:0]       op_code,
  input  logic             op_ready,
  input  logic             op_done,
  output logic [IDX_W-1:0] bit_index,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DBL_REQ  = 3'd1,
    DBL_WAIT = 3'd2,
    ADD_REQ  = 3'd3,
    ADD_WAIT = 3'd4,
    NEXT     = 3'd5,
    FINISH   = 3'd6
  } state_t;

  localparam logic [1:0]       OP_DBL  = 2'b00;
  localparam logic [1:0]       OP_ADD  = 2'b01;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(KEY_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [KEY_W-1:0] scalar_q;
  logic [KEY_W-1:0] scalar_d;
  logic             aborted_q;
  logic             aborted_d;

  // Abort only matters once an operation is running; in IDLE it is a no-op.
  logic abort_hit;
  assign abort_hit = abort && (state != IDLE);

  // ---------------------------------------------------------------------------
  // State and captured-operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx_q     <= '0;
      scalar_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_d;
      idx_q     <= idx_d;
      scalar_q  <= scalar_d;
      aborted_q <= aborted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state;
    idx_d     = idx_q;
    scalar_d  = scalar_q;
    aborted_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          scalar_d = scalar;
          idx_d    = IDX_MSB;
          state_d  = DBL_REQ;
        end
      end

      DBL_REQ: begin
        if (op_ready) begin
          state_d = DBL_WAIT;
        end
      end

      DBL_WAIT: begin
        // The add is issued only for a set bit of the captured scalar.
        if (op_done) begin
          state_d = scalar_q[idx_q] ? ADD_REQ : NEXT;
        end
      end

      ADD_REQ: begin
        if (op_ready) begin
          state_d = ADD_WAIT;
        end
      end

      ADD_WAIT: begin
        if (op_done) begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        // Bit 0 finishes the walk; the index never wraps back to the MSB.
        if (idx_q == '0) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q - IDX_ONE;
          state_d = DBL_REQ;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the state decided, including a same-cycle
    // op_done; the index and operand are left untouched.
    if (abort_hit) begin
      state_d   = IDLE;
      idx_d     = idx_q;
      scalar_d  = scalar_q;
      aborted_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    op_valid = 1'b0;
    op_code  = OP_DBL;
    unique case (state)
      DBL_REQ: begin
        op_valid = 1'b1;
        op_code  = OP_DBL;
      end
      ADD_REQ: begin
        op_valid = 1'b1;
        op_code  = OP_ADD;
      end
      default: begin
        op_valid = 1'b0;
        op_code  = OP_DBL;
      end
    endcase
    // Withdraw the request on abort so no handshake can complete on the edge
    // that abandons the operation.
    if (abort_hit) begin
      op_valid = 1'b0;
    end
  end

  assign bit_index = idx_q;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH) && !abort_hit;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_scalar_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scalar_mult_sequencer
//
// Two sequencer instances (KEY_W=8 and KEY_W=256) share one set of stimulus
// signals; `sel` routes the inputs to one instance and muxes its outputs back.
// A small point-unit responder model answers requests with configurable
// ready stalls and done latency. Expected operation sequences come from the
// double-and-add rule applied directly to the scalar, and completion time from
// the per-op cycle costs the responder itself imposed.
// -----------------------------------------------------------------------------
module tb_scalar_mult_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, abort, op_ready, op_done, sel;
  logic [255:0] scalar;

  logic       v8, b8, d8, a8;
  logic [1:0] c8;
  logic [2:0] i8;
  logic       v256, b256, d256, a256;
  logic [1:0] c256;
  logic [7:0] i256;

  logic s8_start, s8_abort, s8_ready, s8_done;
  logic s256_start, s256_abort, s256_ready, s256_done;
  assign s8_start   = start    & ~sel;
  assign s8_abort   = abort    & ~sel;
  assign s8_ready   = op_ready & ~sel;
  assign s8_done    = op_done  & ~sel;
  assign s256_start = start    &  sel;
  assign s256_abort = abort    &  sel;
  assign s256_ready = op_ready &  sel;
  assign s256_done  = op_done  &  sel;

  logic       op_valid, busy, done, aborted;
  logic [1:0] op_code;
  logic [7:0] bit_index;
  assign op_valid  = sel ? v256 : v8;
  assign op_code   = sel ? c256 : c8;
  assign bit_index = sel ? i256 : {5'd0, i8};
  assign busy      = sel ? b256 : b8;
  assign done      = sel ? d256 : d8;
  assign aborted   = sel ? a256 : a8;

  scalar_mult_sequencer #(.KEY_W(8), .IDX_W(3)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .abort(s8_abort),
    .scalar(scalar[7:0]), .op_valid(v8), .op_code(c8), .op_ready(s8_ready),
    .op_done(s8_done), .bit_index(i8), .busy(b8), .done(d8), .aborted(a8)
  );

  scalar_mult_sequencer #(.KEY_W(256), .IDX_W(8)) dut256 (
    .clk(clk), .reset(reset), .start(s256_start), .abort(s256_abort),
    .scalar(scalar), .op_valid(v256), .op_code(c256), .op_ready(s256_ready),
    .op_done(s256_done), .bit_index(i256), .busy(b256), .done(d256), .aborted(a256)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Responder (point-unit model) state
  int       pending, cnt, cur_hold, cur_lat, rwait, fix_hold, fix_lat, cost;
  bit       rmode, junk;
  bit [1:0] oplog[$];
  int       done_cnt, ab_cnt, cyc;

  task automatic pick_params();
    if (rmode) begin
      cur_hold = $urandom_range(0, 3);
      cur_lat  = $urandom_range(1, 4);
    end else begin
      cur_hold = fix_hold;
      cur_lat  = fix_lat;
    end
  endtask

  // One clock: advance, sample #1 after the edge, then drive the responder
  // inputs for the next edge.
  task automatic tick();
    bit       acc, hold_chk;
    bit [1:0] acode, pcode;
    acc      = op_valid && op_ready;
    acode    = op_code;
    hold_chk = op_valid && !op_ready && !abort && !reset;
    pcode    = op_code;
    @(posedge clk);
    #1;
    cyc++;
    if (done)    done_cnt++;
    if (aborted) ab_cnt++;
    if (hold_chk) begin
      chk("hold_valid", op_valid, 1);
      chk("hold_code", op_code, pcode);
    end
    if (acc) begin
      oplog.push_back(acode);
      pending = 1;
      cnt     = cur_lat;
      cost   += cur_hold + 1 + cur_lat;
      rwait   = 0;
      pick_params();
    end
    if (pending != 0) begin
      if (cnt <= 1) begin
        op_done = 1'b1;
        pending = 0;
      end else begin
        cnt--;
        op_done = 1'b0;
      end
    end else begin
      op_done = junk && ($urandom_range(0, 3) == 0);
    end
    if (op_valid && pending == 0) begin
      if (rwait < cur_hold) begin
        op_ready = 1'b0;
        rwait++;
      end else begin
        op_ready = 1'b1;
      end
    end else begin
      op_ready = junk && ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic begin_op(input bit s, input logic [255:0] k, input bit rm,
                          input int fh, input int fl, input bit jk);
    sel = s; rmode = rm; fix_hold = fh; fix_lat = fl; junk = jk;
    oplog.delete();
    cost = 0; pending = 0; rwait = 0; done_cnt = 0; ab_cnt = 0;
    op_ready = 1'b0; op_done = 1'b0;
    pick_params();
    scalar = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_idx", bit_index, s ? 255 : 7);
  endtask

  task automatic run_op(input bit s, input logic [255:0] k, input bit rm, input int fh,
                        input int fl, input bit jk, input bit midstart,
                        output int nd, output int na);
    int       kw, cyc_s, cyc_d, idx_d, mism;
    bit       seen;
    bit [1:0] expq[$];
    kw = s ? 256 : 8;
    for (int i = kw - 1; i >= 0; i--) begin
      expq.push_back(2'b00);
      if (k[i]) expq.push_back(2'b01);
    end
    begin_op(s, k, rm, fh, fl, jk);
    cyc_s = cyc;
    seen  = 0;
    cyc_d = 0;
    idx_d = 0;
    for (int t = 0; t < 20000 && !seen; t++) begin
      if (midstart && t == 7) begin
        start  = 1'b1;
        scalar = ~k;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        seen  = 1;
        cyc_d = cyc;
        idx_d = bit_index;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("done_cycle", cyc_d - cyc_s, cost + kw);
      chk("done_idx", idx_d, 0);
    end
    junk = 0;
    tick();
    chk("idle_busy", busy, 0);
    chk("done_once", done_cnt, 1);
    chk("no_abort", ab_cnt, 0);
    chk("op_count", oplog.size(), expq.size());
    mism = 0;
    nd = 0;
    na = 0;
    foreach (oplog[i]) begin
      if (oplog[i] == 2'b00) nd++; else na++;
      if (i < expq.size() && oplog[i] != expq[i]) mism++;
    end
    chk("op_seq", mism, 0);
    op_ready = 1'b0;
    op_done  = 1'b0;
  endtask

  typedef struct {
    bit           s;
    logic [255:0] k;
    int           hold;
    int           lat;
    int           exp_d;
    int           exp_a;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   nd, na;
    bit   found;
    logic [255:0] rk;

    vecs[0] = '{0, 256'h81, 0, 2, 8, 2};
    vecs[1] = '{0, 256'h00, 0, 1, 8, 0};
    vecs[2] = '{0, 256'hFF, 1, 3, 8, 8};
    vecs[3] = '{0, 256'hA5, 5, 2, 8, 4};
    vecs[4] = '{1, 256'h0, 0, 2, 256, 0};
    vecs[5] = '{1, 256'h1, 0, 1, 256, 1};
    vecs[6] = '{1, {1'b1, 254'h0, 1'b1}, 0, 2, 256, 2};

    reset = 1'b1; start = 1'b0; abort = 1'b0; op_ready = 1'b0; op_done = 1'b0;
    scalar = '0; sel = 1'b0; junk = 0; rmode = 0; fix_hold = 0; fix_lat = 1;
    cyc = 0; pending = 0; rwait = 0; cur_hold = 0; cur_lat = 1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", op_valid, 0);
      chk("rst_code", op_code, 0);
      chk("rst_idx", bit_index, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
    end
    reset = 1'b0;
    sel   = 1'b0;
    tick();

    // Abort while idle does nothing.
    ab_cnt = 0;
    abort  = 1'b1;
    tick();
    abort  = 1'b0;
    chk("idle_abort_pulse", aborted, 0);
    chk("idle_abort_busy", busy, 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].k, 0, vecs[i].hold, vecs[i].lat, 0, 0, nd, na);
      chk("vec_doubles", nd, vecs[i].exp_d);
      chk("vec_adds", na, vecs[i].exp_a);
    end

    // Abort in ADD_WAIT at index 0x80, coinciding with op_done.
    begin_op(1, {256{1'b1}}, 0, 0, 3, 0);
    found = 0;
    for (int t = 0; t < 20000 && !found; t++) begin
      tick();
      if (pending != 0 && oplog.size() > 0 && oplog[$] == 2'b01 && bit_index == 8'h80)
        found = 1;
    end
    chk("reach_add_wait", found, 1);
    abort   = 1'b1;
    op_done = 1'b1;
    pending = 0;
    tick();
    abort   = 1'b0;
    op_done = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", op_valid, 0);
    tick();
    chk("abort_pulse_end", aborted, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_once", ab_cnt, 1);
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_op(1, rk, 1, 0, 0, 1, 0, nd, na);

    // Reset during DBL_WAIT.
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    begin_op(1, rk, 0, 0, 4, 0);
    found = 0;
    for (int t = 0; t < 20000 && !found; t++) begin
      tick();
      if (pending != 0 && oplog.size() > 3 && oplog[$] == 2'b00) found = 1;
    end
    chk("reach_dbl_wait", found, 1);
    reset   = 1'b1;
    pending = 0;
    op_done = 1'b0;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", op_valid, 0);
    chk("mid_rst_code", op_code, 0);
    chk("mid_rst_idx", bit_index, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_aborted", aborted, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pulses", done_cnt + ab_cnt, 0);

    // Randomized runs: random stalls/latency, spurious ready/done, mid-run start.
    for (int r = 0; r < 6; r++) begin
      rk = {248'h0, 8'($urandom)};
      run_op(0, rk, 1, 0, 0, 1, 1, nd, na);
    end
    for (int r = 0; r < 2; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_op(1, rk, 1, 0, 0, 1, 1, nd, na);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
